// File: rtl/key_pkg.sv
// Shared types and defaults for the two-key debouncer.
// Optional long-press support is enabled with KEY_LONGPRESS_EN.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } key_state_t;

   localparam int DEB_CYCLES_DEF  = 20;
   localparam int LONG_CYCLES_DEF = 1000;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, press/release FSM, counters.
// KEY_LONGPRESS_EN adds a saturating hold counter and long_p pulse.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic start,
`ifdef KEY_LONGPRESS_EN
   output logic long_p,
`endif
   output logic level
);

   if (DEB_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_cfg
      $error("key_debounce_ch: cycle counts must be >= 2");
   end

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync;
   logic          synced;
   key_state_t    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          press_done;

   assign synced     = sync[1];
   assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign press_done = (state == PRESS_WAIT) && synced
                       && (cnt_inc == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= 2'b00;
         state <= IDLE;
         cnt   <= '0;
         start <= 1'b0;
         level <= 1'b0;
      end else begin
         sync  <= {sync[0], key};
         start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (synced) begin
                  cnt   <= '0;
                  state <= PRESS_WAIT;
               end
            end
            PRESS_WAIT: begin
               if (!synced) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt_inc;
                  if (press_done) begin
                     state <= PRESSED;
                     start <= 1'b1;
                     level <= 1'b1;
                  end
               end
            end
            PRESSED: begin
               if (!synced) begin
                  cnt   <= '0;
                  state <= RELEASE_WAIT;
               end
            end
            RELEASE_WAIT: begin
               if (synced) begin
                  state <= PRESSED;
               end else begin
                  // the zero seen in PRESSED is the first of the run
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_LAST) begin
                     state <= IDLE;
                     level <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef KEY_LONGPRESS_EN
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   logic [HW-1:0] hold;
   logic [HW-1:0] hold_inc;

   assign hold_inc = (hold == HOLD_MAX) ? hold : hold + 1'b1;

   // bounce back from RELEASE_WAIT keeps the count: one pulse per press
   always_ff @(posedge clk) begin
      if (rst) begin
         hold   <= '0;
         long_p <= 1'b0;
      end else begin
         long_p <= 1'b0;
         if (press_done) begin
            hold <= '0;
         end else if (state == PRESSED || state == RELEASE_WAIT) begin
            hold <= hold_inc;
            if (hold != HOLD_MAX && hold_inc == HOLD_LAST) begin
               long_p <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: rtl/key_debounce.sv
// Two independent debounced push-button channels, {key2, key1}.
// KEY_LONGPRESS_EN adds the long_p long-press pulse outputs.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key1,
   input  logic       key2,
   output logic       start1,
   output logic       start2,
`ifdef KEY_LONGPRESS_EN
   output logic [1:0] long_p,
`endif
   output logic [1:0] level
);

   key_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
   ) u_ch1 (
      .clk   (clk),
      .rst   (rst),
      .key   (key1),
      .start (start1),
`ifdef KEY_LONGPRESS_EN
      .long_p(long_p[0]),
`endif
      .level (level[0])
   );

   key_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
   ) u_ch2 (
      .clk   (clk),
      .rst   (rst),
      .key   (key2),
      .start (start2),
`ifdef KEY_LONGPRESS_EN
      .long_p(long_p[1]),
`endif
      .level (level[1])
   );

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (long-press checks under KEY_LONGPRESS_EN).
module tb_key_debounce;

   logic       clk = 1'b0;
   logic       rst;
   logic       key1;
   logic       key2;
   logic       start1;
   logic       start2;
   logic [1:0] level;
`ifdef KEY_LONGPRESS_EN
   logic [1:0] long_p;
`endif

   int tests = 0;
   int fails = 0;

   key_debounce dut (
      .clk   (clk),
      .rst   (rst),
      .key1  (key1),
      .key2  (key2),
      .start1(start1),
      .start2(start2),
`ifdef KEY_LONGPRESS_EN
      .long_p(long_p),
`endif
      .level (level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int cyc,
                      input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s @%0d: observed %0h expected %0h",
                tag, cyc, obs, exp);
      end
   endtask

   initial begin
      rst  = 1'b1;
      key1 = 1'b0;
      key2 = 1'b0;
      repeat (3) tick();
      chk("rst_start1", 0, 32'(start1), 0);
      chk("rst_start2", 0, 32'(start2), 0);
      chk("rst_level", 0, 32'(level), 0);
`ifdef KEY_LONGPRESS_EN
      chk("rst_long", 0, 32'(long_p), 0);
`endif
      rst = 1'b0;
      repeat (3) tick();

      // clean press of key1, 30 cycles
      for (int i = 1; i <= 30; i++) begin
         key1 = 1'b1;
         tick();
         chk("p1_start1", i, 32'(start1), 32'(i == 22));
         chk("p1_level", i, 32'(level), (i >= 22) ? 1 : 0);
         chk("p1_start2", i, 32'(start2), 0);
      end
      key1 = 1'b0;
      repeat (30) tick();
      chk("p1_released", 0, 32'(level), 0);

      // bouncing key1 never confirms
      for (int i = 1; i <= 85; i++) begin
         key1 = (i <= 60) ? 1'(((i - 1) / 3) % 2 == 0) : 1'b0;
         tick();
         chk("bounce_start1", i, 32'(start1), 0);
         chk("bounce_level", i, 32'(level), 0);
      end

      // simultaneous press
      for (int i = 1; i <= 40; i++) begin
         key1 = 1'b1;
         key2 = 1'b1;
         tick();
         chk("both_start1", i, 32'(start1), 32'(i == 22));
         chk("both_start2", i, 32'(start2), 32'(i == 22));
         chk("both_level", i, 32'(level), (i >= 22) ? 3 : 0);
      end
      key1 = 1'b0;
      key2 = 1'b0;
      repeat (30) tick();
      chk("both_released", 0, 32'(level), 0);

      // key2 held with a 5-cycle release glitch
      for (int i = 1; i <= 80; i++) begin
         key2 = !(i >= 50 && i < 55);
         tick();
         chk("glitch_start2", i, 32'(start2), 32'(i == 22));
         chk("glitch_level", i, 32'(level), (i >= 22) ? 2 : 0);
      end
      key2 = 1'b0;
      repeat (30) tick();
      chk("glitch_released", 0, 32'(level), 0);

      // reset in the middle of a debounce
      for (int i = 1; i <= 10; i++) begin
         key1 = 1'b1;
         tick();
         chk("pre_rst_start1", i, 32'(start1), 0);
      end
      rst = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         tick();
         chk("in_rst_start1", i, 32'(start1), 0);
         chk("in_rst_level", i, 32'(level), 0);
      end
      for (int i = 1; i <= 30; i++) begin
         rst = 1'b0;
         tick();
         chk("post_rst_start1", i, 32'(start1), 32'(i == 22));
         chk("post_rst_level", i, 32'(level), (i >= 22) ? 1 : 0);
      end
      key1 = 1'b0;
      repeat (30) tick();
      chk("post_rst_released", 0, 32'(level), 0);

`ifdef KEY_LONGPRESS_EN
      // long press on key1
      for (int i = 1; i <= 1100; i++) begin
         key1 = 1'b1;
         tick();
         chk("long_p", i, 32'(long_p), (i == 1021) ? 1 : 0);
         chk("long_start1", i, 32'(start1), 32'(i == 22));
      end
      key1 = 1'b0;
      repeat (30) tick();
      chk("long_released", 0, 32'(level), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
